// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin winner function for the fifo write-port arbiter
// and any later bus arbiter that needs the same fairness rule.
package fifo_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {IDLE, BURST} arb_state_t;

    // Winner = first requester found scanning last+1, last+2, ... modulo n.
    // Scanning from the far end down lets the nearest hit overwrite farther ones.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   last,
        input int                 n
    );
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cidx;
        int               cand;
        win = last;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                cand = (int'(last) + k) % n;
                cidx = IDX_W'(cand);
                if (req[cidx]) begin
                    win = cidx;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: given a request vector and the
// previous winner, returns whether anyone requests and who wins.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [IDX_W-1:0]   last_ext;
    logic [IDX_W-1:0]   pick;

    always_comb begin
        req_ext            = '0;
        req_ext[N-1:0]     = req;
        last_ext           = '0;
        last_ext[IW-1:0]   = last;
        pick               = rr_next(req_ext, last_ext, N);
        idx                = pick[IW-1:0];
        valid              = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular sharing of one fifo write port among NUM_REQ producers.
// Handshake: a word moves when req[i] and gnt[i] are both high in the same cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t      state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic            xfer;
    logic            release_burst;

    rr_pick #(.N(NUM_REQ), .IW(OW)) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        release_burst = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
                release_burst = (xfer & req_last[owner_q])
                              | (xfer & (cnt_q == CW'(MAX_BURST - 1)))
                              | ~req[owner_q];
                if (release_burst) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the owner's slice is ever selected, so junk on other slices cannot leak out.
    // Grants are held off during reset so a word offered in that cycle is not written.
    always_comb begin
        gnt         = '0;
        xfer        = 1'b0;
        fifo_wr     = 1'b0;
        fifo_w_data = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == BURST && !reset) begin
            gnt[owner_q] = ~fifo_full;
            xfer         = req[owner_q] & ~fifo_full;
            fifo_wr      = xfer;
        end
        busy  = (state_q == BURST);
        owner = owner_q;
    end

endmodule
